// File: rtl/fanin_merge_pkg.sv
// Shared sizing and occupancy encoding for the fan-in merge arbiter.
package fanin_merge_pkg;
    localparam int NUM_SRC = 8;
    localparam int DATA_W  = 8;
    localparam int SRC_W   = $clog2(NUM_SRC);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;
endpackage

// File: rtl/fanin_merge_arbiter_rr.sv
// Combinational round-robin picker: search starts one past the last grant and wraps.
module rr_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_SRC-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_gnt_idx,
    output logic               o_any_gnt
);
    always_comb begin
        int j;
        logic found;
        o_gnt     = '0;
        o_gnt_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            j = (int'(i_last_grant) + k) % NUM_SRC;
            if (!found && i_req[j]) begin
                o_gnt[j]  = 1'b1;
                o_gnt_idx = IDX_W'(j);
                found     = 1'b1;
            end
        end
        o_any_gnt = found;
    end
endmodule

// File: rtl/fanin_merge_arbiter.sv
// Merges NUM_SRC valid/ready sources onto one stream through a 2-entry in-order buffer.
module fanin_merge_arbiter #(
    parameter int NUM_SRC = fanin_merge_pkg::NUM_SRC,
    parameter int DATA_W  = fanin_merge_pkg::DATA_W
) (
    input  logic                       iccad_clk,
    input  logic                       iccad_rst_n,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data,
    output logic [NUM_SRC-1:0]         src_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_SRC)-1:0] out_src,
    input  logic                       out_ready,
    output logic [15:0]                accept_cnt
);
    import fanin_merge_pkg::*;

    localparam int SW = $clog2(NUM_SRC);

    occ_e                   r_state, w_state_nxt;
    logic [SW-1:0]          r_last_grant;
    logic [1:0][DATA_W-1:0] r_data;
    logic [1:0][SW-1:0]     r_src;
    logic [15:0]            r_cnt;

    logic [NUM_SRC-1:0]     w_gnt;
    logic [SW-1:0]          w_gnt_idx;
    logic                   w_any_gnt;
    logic                   w_space;
    logic                   w_push;
    logic                   w_pop;
    logic [DATA_W-1:0]      w_new_data;

    rr_arbiter #(.NUM_SRC(NUM_SRC), .IDX_W(SW)) u_rr (
        .i_req        (src_valid),
        .i_last_grant (r_last_grant),
        .o_gnt        (w_gnt),
        .o_gnt_idx    (w_gnt_idx),
        .o_any_gnt    (w_any_gnt)
    );

    // A full buffer can still accept when the head drains in the same cycle.
    assign w_space    = (r_state != FULL) || out_ready;
    assign w_push     = iccad_rst_n && w_any_gnt && w_space;
    assign src_ready  = w_push ? w_gnt : '0;
    assign w_pop      = out_valid && out_ready;
    assign w_new_data = src_data[w_gnt_idx*DATA_W +: DATA_W];

    assign out_valid  = (r_state != EMPTY);
    assign out_data   = r_data[0];
    assign out_src    = r_src[0];
    assign accept_cnt = r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_push) w_state_nxt = ONE;
            ONE: begin
                if (w_push && !w_pop)      w_state_nxt = FULL;
                else if (w_pop && !w_push) w_state_nxt = EMPTY;
            end
            FULL:    if (w_pop && !w_push) w_state_nxt = ONE;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
        if (!iccad_rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Entry 0 is the head; a pop shifts entry 1 forward, and a push into
    // the slot that becomes free overrides the shift where they collide.
    always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
        if (!iccad_rst_n) begin
            r_data       <= '0;
            r_src        <= '0;
            r_last_grant <= SW'(NUM_SRC - 1);
            r_cnt        <= '0;
        end else begin
            if (w_pop) begin
                r_data[0] <= r_data[1];
                r_src[0]  <= r_src[1];
            end
            if (w_push) begin
                if (r_state == EMPTY || (r_state == ONE && w_pop)) begin
                    r_data[0] <= w_new_data;
                    r_src[0]  <= w_gnt_idx;
                end else begin
                    r_data[1] <= w_new_data;
                    r_src[1]  <= w_gnt_idx;
                end
                r_last_grant <= w_gnt_idx;
                r_cnt        <= r_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_fanin_merge_arbiter.sv
// Directed vector table plus hand-written reset, stall and counter-wrap sequences.
module tb_fanin_merge_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  src_valid;
    logic [63:0] src_data;
    logic [7:0]  src_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_src;
    logic        out_ready;
    logic [15:0] accept_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fanin_merge_arbiter #(.NUM_SRC(8), .DATA_W(8)) dut (
        .iccad_clk   (clk),
        .iccad_rst_n (rst_n),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_ready   (out_ready),
        .accept_cnt  (accept_cnt)
    );

    typedef struct {
        logic [7:0]  sv;
        logic        ordy;
        logic [7:0]  rdy;
        logic        ov;
        logic [2:0]  os;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    function automatic logic [7:0] dat(input int i);
        return 8'((165 + 17 * i) & 255);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) src_data[i*8 +: 8] = dat(i);
        rst_n     = 1'b0;
        src_valid = 8'hFF;
        out_ready = 1'b0;

        //          sv     ordy  rdy    ov    os    cnt
        tbl[0]  = '{8'h01, 1'b1, 8'h01, 1'b1, 3'd0, 16'd1};
        tbl[1]  = '{8'h80, 1'b1, 8'h80, 1'b1, 3'd7, 16'd2};
        for (int k = 0; k < 8; k++)
            tbl[2+k] = '{8'hFF, 1'b1, 8'(1 << k), 1'b1, 3'(k), 16'(3 + k)};
        tbl[10] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 16'd10};
        tbl[11] = '{8'h0C, 1'b0, 8'h04, 1'b1, 3'd2, 16'd11};
        tbl[12] = '{8'h0C, 1'b0, 8'h08, 1'b1, 3'd2, 16'd12};
        tbl[13] = '{8'h0C, 1'b0, 8'h00, 1'b1, 3'd2, 16'd12};
        tbl[14] = '{8'h0C, 1'b1, 8'h04, 1'b1, 3'd3, 16'd13};
        tbl[15] = '{8'h00, 1'b1, 8'h00, 1'b1, 3'd2, 16'd13};
        tbl[16] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 16'd13};
        tbl[17] = '{8'h80, 1'b1, 8'h80, 1'b1, 3'd7, 16'd14};
        tbl[18] = '{8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 16'd15};
        tbl[19] = '{8'h00, 1'b0, 8'h00, 1'b1, 3'd0, 16'd15};
        tbl[20] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 16'd15};
        tbl[21] = '{8'h22, 1'b1, 8'h02, 1'b1, 3'd1, 16'd16};
        tbl[22] = '{8'h22, 1'b1, 8'h20, 1'b1, 3'd5, 16'd17};
        tbl[23] = '{8'h22, 1'b1, 8'h02, 1'b1, 3'd1, 16'd18};
        tbl[24] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 16'd18};

        // Reset state, with every source requesting.
        #12;
        check("rst.src_ready", 32'(src_ready), 32'h0);
        check("rst.out_valid", 32'(out_valid), 32'h0);
        check("rst.out_data", 32'(out_data), 32'h0);
        check("rst.out_src", 32'(out_src), 32'h0);
        check("rst.accept_cnt", 32'(accept_cnt), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        src_valid = 8'h00;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            src_valid = tbl[i].sv;
            out_ready = tbl[i].ordy;
            #1;
            check($sformatf("vec%0d.src_ready", i), 32'(src_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            check($sformatf("vec%0d.accept_cnt", i), 32'(accept_cnt), 32'(tbl[i].cnt));
            if (tbl[i].ov) begin
                check($sformatf("vec%0d.out_src", i), 32'(out_src), 32'(tbl[i].os));
                check($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(dat(int'(tbl[i].os))));
            end
        end

        // Fill the buffer from sources 5 then 0 while stalled, then reset mid-cycle.
        @(negedge clk);
        src_valid = 8'h21;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("fill.src_ready_full", 32'(src_ready), 32'h0);
        check("fill.out_src", 32'(out_src), 32'd5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 32'(out_valid), 32'h0);
        check("midrst.src_ready", 32'(src_ready), 32'h0);
        check("midrst.accept_cnt", 32'(accept_cnt), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        src_valid = 8'h00;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("postrst.no_output", 32'(out_valid), 32'h0);
        @(negedge clk);
        src_valid = 8'h03;
        #1;
        check("postrst.first_grant", 32'(src_ready), 32'h01);
        @(posedge clk);
        #1;
        check("postrst.out_src", 32'(out_src), 32'd0);
        check("postrst.accept_cnt", 32'(accept_cnt), 32'd1);

        // Sustained single source at full rate up to and across the counter wrap.
        @(negedge clk);
        src_valid = 8'h01;
        repeat (65534) @(posedge clk);
        #1;
        check("wrap.cnt_ffff", 32'(accept_cnt), 32'hFFFF);
        check("wrap.out_valid", 32'(out_valid), 32'h1);
        check("wrap.src_ready", 32'(src_ready), 32'h01);
        @(posedge clk);
        #1;
        check("wrap.cnt_0000", 32'(accept_cnt), 32'h0000);
        check("wrap.out_data", 32'(out_data), 32'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
